// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// bus_pkg : arbiter state encoding and default bus-mux widths
// Rev 1.0
// ============================================================================
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } arb_state_t;

  localparam int DEFAULT_NUM_INPUT = 8;
  localparam int DEFAULT_SEL_BIT   = 3;
  localparam int DEFAULT_MAX_BURST = 16;

endpackage
`default_nettype wire

// File: rtl/rr_priority_pick.sv
`default_nettype none
// ============================================================================
// rr_priority_pick : combinational masked round-robin search starting above
//                    last_owner, wrapping to index 0
// Rev 1.0
// ============================================================================
module rr_priority_pick
  import bus_pkg::*;
#(
  parameter int NUM_INPUT = DEFAULT_NUM_INPUT,
  parameter int SEL_BIT   = DEFAULT_SEL_BIT
) (
  input  logic [NUM_INPUT-1:0] req,
  input  logic [SEL_BIT-1:0]   last_owner,
  output logic                 found,
  output logic [SEL_BIT-1:0]   idx
);

  logic [NUM_INPUT-1:0] w_above;
  logic [NUM_INPUT-1:0] w_masked;
  logic [NUM_INPUT-1:0] w_search;

  always_comb begin
    w_above = '0;
    for (int i = 0; i < NUM_INPUT; i++) begin
      w_above[i] = (i > int'(last_owner));
    end
  end

  // Nothing above the last owner requests -> fall back to the unmasked vector (wrap).
  assign w_masked = req & w_above;
  assign w_search = (|w_masked) ? w_masked : req;
  assign found    = |req;

  always_comb begin
    idx = '0;
    for (int i = NUM_INPUT - 1; i >= 0; i--) begin
      if (w_search[i]) begin
        idx = SEL_BIT'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// bus_arbiter : round-robin tristate-bus arbiter with one-cycle turnaround;
//               optional burst limit under BUS_ARBITER_BURST_LIMIT_EN
// Rev 1.0
// ============================================================================
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_INPUT = DEFAULT_NUM_INPUT,
  parameter int SEL_BIT   = DEFAULT_SEL_BIT,
  parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_INPUT-1:0] req_in,
  output logic [NUM_INPUT-1:0] grant_out,
  output logic [SEL_BIT-1:0]   sel_out,
  output logic                 bus_valid_out,
  output logic                 busy_out
);

  generate
    if (NUM_INPUT > (2 ** SEL_BIT) || MAX_BURST < 1 || MAX_BURST > 65535) begin : g_param_check
      $error("bus_arbiter: illegal parameter set");
    end
  endgenerate

  arb_state_t           r_state;
  logic [SEL_BIT-1:0]   r_last_owner;
  logic                 w_found;
  logic [SEL_BIT-1:0]   w_pick_idx;
  logic [NUM_INPUT-1:0] w_pick_onehot;
  logic                 w_owner_req;
  logic                 w_force_turn;

  rr_priority_pick #(
    .NUM_INPUT (NUM_INPUT),
    .SEL_BIT   (SEL_BIT)
  ) u_pick (
    .req        (req_in),
    .last_owner (r_last_owner),
    .found      (w_found),
    .idx        (w_pick_idx)
  );

  always_comb begin
    w_pick_onehot = '0;
    for (int i = 0; i < NUM_INPUT; i++) begin
      w_pick_onehot[i] = w_found && (w_pick_idx == SEL_BIT'(i));
    end
  end

  // grant_out is one-hot on the owner while in GRANT, so masking gives the owner's request.
  assign w_owner_req = |(req_in & grant_out);

`ifdef BUS_ARBITER_BURST_LIMIT_EN
  localparam int                 BURST_W    = $clog2(MAX_BURST + 1);
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST);
  localparam logic [BURST_W-1:0] BURST_ONE  = BURST_W'(1);

  logic [BURST_W-1:0] r_burst_cnt;
  logic               w_burst_at_limit;
  logic               w_other_req;
  logic               w_grant_entry;

  assign w_other_req      = |(req_in & ~grant_out);
  assign w_burst_at_limit = (r_burst_cnt == BURST_LAST);
  assign w_force_turn     = (r_state == ST_GRANT) && w_burst_at_limit && w_other_req;
  assign w_grant_entry    = (r_state != ST_GRANT) && w_found;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_burst_cnt <= '0;
    end else if (r_state == ST_GRANT && w_owner_req && !w_force_turn) begin
      // Uncontested at the limit: reload so the owner keeps the bus.
      r_burst_cnt <= w_burst_at_limit ? BURST_ONE : r_burst_cnt + BURST_ONE;
    end else if (w_grant_entry) begin
      r_burst_cnt <= BURST_ONE;
    end else begin
      r_burst_cnt <= '0;
    end
  end
`else
  assign w_force_turn = 1'b0;
`endif

  // sel_out only changes on GRANT entry so the bus mux never switches mid-turnaround.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      grant_out     <= '0;
      sel_out       <= '0;
      bus_valid_out <= 1'b0;
      busy_out      <= 1'b0;
      r_last_owner  <= SEL_BIT'(NUM_INPUT - 1);
    end else begin
      case (r_state)
        ST_IDLE, ST_TURN: begin
          if (w_found) begin
            r_state       <= ST_GRANT;
            grant_out     <= w_pick_onehot;
            sel_out       <= w_pick_idx;
            bus_valid_out <= 1'b1;
            busy_out      <= 1'b1;
            r_last_owner  <= w_pick_idx;
          end else begin
            r_state       <= ST_IDLE;
            grant_out     <= '0;
            bus_valid_out <= 1'b0;
            busy_out      <= 1'b0;
          end
        end
        ST_GRANT: begin
          if (!w_owner_req || w_force_turn) begin
            r_state       <= ST_TURN;
            grant_out     <= '0;
            bus_valid_out <= 1'b0;
            busy_out      <= 1'b1;
          end
        end
        default: begin
          r_state       <= ST_IDLE;
          grant_out     <= '0;
          bus_valid_out <= 1'b0;
          busy_out      <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// tb_bus_arbiter : directed scoreboard bench for bus_arbiter (MAX_BURST = 4)
// Rev 1.0
// ============================================================================
module tb_bus_arbiter;

  localparam int NUM_INPUT = 8;
  localparam int SEL_BIT   = 3;
  localparam int MAX_BURST = 4;

  typedef struct packed {
    logic [7:0] grant;
    logic [2:0] sel;
    logic       valid;
    logic       busy;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req_in;
  logic [7:0] grant_out;
  logic [2:0] sel_out;
  logic       bus_valid_out;
  logic       busy_out;

  exp_t  exp_q[$];
  string tag_q[$];
  int    errors = 0;
  int    checks = 0;

  bus_arbiter #(
    .NUM_INPUT (NUM_INPUT),
    .SEL_BIT   (SEL_BIT),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_in        (req_in),
    .grant_out     (grant_out),
    .sel_out       (sel_out),
    .bus_valid_out (bus_valid_out),
    .busy_out      (busy_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_outputs(input string tag, input exp_t e);
    chk({tag, ".grant"}, 32'(grant_out),     32'(e.grant));
    chk({tag, ".sel"},   32'(sel_out),       32'(e.sel));
    chk({tag, ".valid"}, 32'(bus_valid_out), 32'(e.valid));
    chk({tag, ".busy"},  32'(busy_out),      32'(e.busy));
  endtask

  // Drive one request vector, expect the given outputs after the next edge.
  task automatic cyc(input string tag, input logic [7:0] r, input logic [7:0] g,
                     input logic [2:0] s, input logic b);
    exp_t  e;
    exp_t  got;
    string t;
    req_in  = r;
    e.grant = g;
    e.sel   = s;
    e.valid = (g != 8'h00);
    e.busy  = b;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    t   = tag_q.pop_front();
    check_outputs(t, got);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t zero_e;
    zero_e = '0;
    rst    = 1'b1;
    req_in = 8'h00;
    @(posedge clk);
    #1;
    check_outputs("reset", zero_e);
    rst = 1'b0;

    for (int k = 0; k < 10; k++) cyc("idle_quiet", 8'h00, 8'h00, 3'd0, 1'b0);

    cyc("grant_src0",      8'h05, 8'h01, 3'd0, 1'b1);
    cyc("hold_src0",       8'h05, 8'h01, 3'd0, 1'b1);
    cyc("turn_after0",     8'h04, 8'h00, 3'd0, 1'b1);
    cyc("grant_src2",      8'h04, 8'h04, 3'd2, 1'b1);
    cyc("turn_after2",     8'h00, 8'h00, 3'd2, 1'b1);
    cyc("idle_after2",     8'h00, 8'h00, 3'd2, 1'b0);

    cyc("grant_src7",      8'h80, 8'h80, 3'd7, 1'b1);
    cyc("turn_after7",     8'h00, 8'h00, 3'd7, 1'b1);
    cyc("idle_after7",     8'h00, 8'h00, 3'd7, 1'b0);
    cyc("wrap_src0",       8'h81, 8'h01, 3'd0, 1'b1);
    cyc("wrap_turn",       8'h80, 8'h00, 3'd0, 1'b1);
    cyc("wrap_src7",       8'h80, 8'h80, 3'd7, 1'b1);
    cyc("wrap_rel",        8'h00, 8'h00, 3'd7, 1'b1);
    cyc("wrap_idle",       8'h00, 8'h00, 3'd7, 1'b0);

    cyc("pulse_src3",      8'h08, 8'h08, 3'd3, 1'b1);
    cyc("pulse_turn",      8'h00, 8'h00, 3'd3, 1'b1);
    cyc("pulse_idle",      8'h00, 8'h00, 3'd3, 1'b0);

`ifdef BUS_ARBITER_BURST_LIMIT_EN
    for (int k = 0; k < 4; k++) cyc("burst_src0", 8'h03, 8'h01, 3'd0, 1'b1);
    cyc("burst_turn0",     8'h03, 8'h00, 3'd0, 1'b1);
    for (int k = 0; k < 4; k++) cyc("burst_src1", 8'h03, 8'h02, 3'd1, 1'b1);
    cyc("burst_turn1",     8'h03, 8'h00, 3'd1, 1'b1);
    cyc("burst_src0_again", 8'h03, 8'h01, 3'd0, 1'b1);
`else
    for (int k = 0; k < 10; k++) cyc("contend_hold0", 8'h03, 8'h01, 3'd0, 1'b1);
`endif
    for (int k = 0; k < 10; k++) cyc("solo_src0", 8'h01, 8'h01, 3'd0, 1'b1);
    cyc("solo_rel",        8'h00, 8'h00, 3'd0, 1'b1);
    cyc("solo_idle",       8'h00, 8'h00, 3'd0, 1'b0);

    cyc("own4",            8'h10, 8'h10, 3'd4, 1'b1);
    cyc("own4_hold",       8'h10, 8'h10, 3'd4, 1'b1);
    rst    = 1'b1;
    req_in = 8'hFF;
    #1;
    check_outputs("async_rst", zero_e);
    #1;
    rst = 1'b0;
    cyc("rst_first",       8'hFF, 8'h01, 3'd0, 1'b1);
    cyc("rst_turn",        8'hFE, 8'h00, 3'd0, 1'b1);
    cyc("rst_next",        8'hFE, 8'h02, 3'd1, 1'b1);
    cyc("end_rel",         8'h00, 8'h00, 3'd1, 1'b1);
    cyc("end_idle",        8'h00, 8'h00, 3'd1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter that owns the select side of the shared tristate data bus. It takes per-source bus requests and issues one registered, one-hot grant. It drives the matching select index into the bus tristate mux, and inserts a mandatory one-cycle turnaround between owners so two drivers never overlap on the bus net. An optional burst limit forces ownership to rotate under contention.

## Interface
- NUM_INPUT, 8, number of requesting sources; must satisfy NUM_INPUT <= 2**SEL_BIT.
- SEL_BIT, 3, width of the select index driven to the bus mux.
- MAX_BURST, 16, maximum consecutive owned cycles under contention; 1..65535; used only with the burst-limit feature.

- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_in  input  NUM_INPUT  per-source request; bit i high means source i wants the bus.
- grant_out  output  NUM_INPUT  registered one-hot grant; all zero when no owner.
- sel_out  output  SEL_BIT  registered index of the current or most recent owner; connects to the bus mux select.
- bus_valid_out  output  1  high only in cycles where the granted source's data is valid on the bus.
- busy_out  output  1  high in GRANT and TURN states.

## Operation
- States:
  - IDLE: no owner.
  - GRANT: one owner.
  - TURN: one-cycle turnaround, no owner.
- IDLE transitions:
  - req_in != 0 -> GRANT. Owner is the first set bit searching upward from (last_owner+1) mod NUM_INPUT, with wrap.
  - req_in == 0 -> stay in IDLE.
- GRANT transitions:
  - Owner's req_in bit sampled low -> TURN. Other requesters are ignored this cycle.
  - Owner's req_in bit high -> stay in GRANT. Exception: a burst-limit expiry, see Configuration.
- TURN transitions:
  - Always exactly one cycle; grant_out=0, bus_valid_out=0.
  - Then -> GRANT with the round-robin search if req_in != 0, else -> IDLE.
- Output values by state:
  - In GRANT: grant_out has exactly the owner bit set, sel_out = owner index, bus_valid_out=1.
  - In IDLE and TURN: sel_out holds the last owner index, so no new driver is enabled mid-turnaround. grant_out=0, bus_valid_out=0.
- last_owner updates on each GRANT entry. The round-robin pointer never advances without a grant.
- Minimum grant length is 1 cycle. A request pulse of a single cycle that is sampled in IDLE still receives a 1-cycle grant.
- Request bits at or above NUM_INPUT do not exist; the search covers only 0..NUM_INPUT-1.
- Reset values:
  - State IDLE, grant_out=0, sel_out=0, bus_valid_out=0, busy_out=0.
  - last_owner = NUM_INPUT-1, so index 0 has first priority.
- Reset asserted mid-GRANT: all outputs clear asynchronously and no turnaround is emitted. After release, arbitration restarts from index 0 priority.

## Timing
- Latency from request sampled high in IDLE at edge N to grant_out/sel_out/bus_valid_out valid after edge N+1: 1 cycle.
- Release: owner req low at edge N -> grant_out=0 after N, TURN during N..N+1 -> next owner granted after edge N+1.
- Handoff gap between back-to-back owners: exactly 1 dead cycle.
- All outputs come directly from flops; no combinational path from req_in to any output.

## Configuration
- Macro: BUS_ARBITER_BURST_LIMIT_EN.
- Defined:
  - A counter (width $clog2(MAX_BURST+1)) counts owned cycles from 1 at GRANT entry.
  - At count == MAX_BURST with any other req_in bit high, the arbiter goes to TURN even if the owner still requests; the counter then clears.
  - With no other requester at the limit, the counter reloads to 1 and the owner keeps the bus.
- Undefined: no counter exists; the owner holds the bus while its request stays high, and MAX_BURST is unused.

## Structure
- Shared package bus_pkg holds the state encoding (IDLE/GRANT/TURN) and the default select and width constants shared with the bus mux.
- One sub-module, rr_priority_pick: a combinational masked round-robin search that takes req and last_owner and returns a found flag plus an index.

## Test plan
- Reset, then req_in=8'h00 for 10 cycles -> state IDLE, grant_out=0, sel_out=0, bus_valid_out=0 throughout.
- req_in=8'h05 held -> grant_out=8'h01, sel_out=0 one cycle after the first edge. Drop bit0 -> one TURN cycle (grant_out=0, sel_out=0), then grant_out=8'h04, sel_out=2.
- Last owner 7, req_in=8'h81 -> next grant goes to source 0 (wrap), then to source 7 after source 0 releases.
- With BUS_ARBITER_BURST_LIMIT_EN defined, MAX_BURST=4, req_in=8'h03 held -> source 0 granted for 4 cycles, TURN, source 1 for 4 cycles, repeating. With req_in=8'h01 only -> continuous grant with no TURN.
- rst pulsed while grant_out=8'h10 -> outputs clear immediately. After release with req_in=8'hFF -> first grant goes to source 0.
- Single-cycle req pulse on bit3 in IDLE -> exactly 1 grant cycle (grant_out=8'h08), then TURN, then IDLE.
